// File: rtl/pipelined_subtractor.sv
// ---------------------------------------------------------------------------
// pipelined_subtractor
//   Borrow-lookahead subtractor computing (a_i - b_i - borrow_i) mod 2^WIDTH,
//   split into STAGES equal chunks of CW = WIDTH/STAGES bits. Each stage
//   resolves one chunk's borrow chain and registers the partial result. The
//   whole pipeline advances together and freezes under output backpressure.
//
// Parameters
//   WIDTH   operand/result width, must be divisible by STAGES
//   STAGES  number of pipeline stages, 1..WIDTH
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-high reset
//   a_i, b_i    minuend / subtrahend
//   borrow_i    borrow-in (weight 1 at bit 0)
//   valid_i     input transaction valid
//   ready_o     pipeline accepts an input this cycle
//   diff_o      (a - b - borrow_in) mod 2^WIDTH
//   borrow_o    final borrow-out (unsigned a < b + borrow_in)
//   overflow_o  signed overflow of the subtraction
//   valid_o     output transaction valid
//   ready_i     downstream accepts the output
// ---------------------------------------------------------------------------

// One chunk of the borrow chain; purely combinational.
module pipelined_subtractor_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          bin,
    output logic [CW-1:0] diff,
    output logic          bout
);
    always_comb begin
        logic br;
        br   = bin;
        diff = '0;
        for (int j = 0; j < CW; j++) begin
            diff[j] = a[j] ^ b[j] ^ br;
            // generate when a=0,b=1; propagate when a==b
            br      = (~a[j] & b[j]) | (~(a[j] ^ b[j]) & br);
        end
        bout = br;
    end
endmodule

module pipelined_subtractor #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o,
    output logic             valid_o,
    input  logic             ready_i
);
    localparam int CW = WIDTH / STAGES;

    // Per-stage registers. a/b are carried full width: the bits above the
    // completed chunk feed later stages, and the MSBs feed overflow.
    logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, d_q;
    logic [STAGES-1:0]            br_q;
    logic [STAGES:0]              vld_pipe;
    logic                         adv;

    assign vld_pipe[0] = valid_i;
    assign adv         = ~vld_pipe[STAGES] | ready_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_in, b_in, d_in, d_nxt;
        logic             br_in;
        logic [CW-1:0]    chunk_d;
        logic             chunk_b;
        logic [WIDTH-1:0] a_r, b_r, d_r;
        logic             br_r, v_r;

        if (k == 0) begin : g_first
            assign a_in  = a_i;
            assign b_in  = b_i;
            assign br_in = borrow_i;
            assign d_in  = '0;
        end else begin : g_next
            assign a_in  = a_q[k-1];
            assign b_in  = b_q[k-1];
            assign br_in = br_q[k-1];
            assign d_in  = d_q[k-1];
        end

        pipelined_subtractor_chunk #(.CW(CW)) u_chunk (
            .a    (a_in[k*CW +: CW]),
            .b    (b_in[k*CW +: CW]),
            .bin  (br_in),
            .diff (chunk_d),
            .bout (chunk_b)
        );

        always_comb begin
            d_nxt              = d_in;
            d_nxt[k*CW +: CW]  = chunk_d;
        end

        // Data is loaded regardless of valid; only the valid bit gives it
        // meaning. Zeroing on reset keeps the outputs at 0 after reset.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                a_r  <= '0;
                b_r  <= '0;
                d_r  <= '0;
                br_r <= 1'b0;
                v_r  <= 1'b0;
            end else if (adv) begin
                a_r  <= a_in;
                b_r  <= b_in;
                d_r  <= d_nxt;
                br_r <= chunk_b;
                v_r  <= vld_pipe[k];
            end
        end

        assign a_q[k]        = a_r;
        assign b_q[k]        = b_r;
        assign d_q[k]        = d_r;
        assign br_q[k]       = br_r;
        assign vld_pipe[k+1] = v_r;
    end

    assign ready_o    = adv;
    assign valid_o    = vld_pipe[STAGES];
    assign diff_o     = d_q[STAGES-1];
    assign borrow_o   = br_q[STAGES-1];
    assign overflow_o = (a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1])
                      & (d_q[STAGES-1][WIDTH-1] ^ a_q[STAGES-1][WIDTH-1]);

    // Already-consumed operand bits are intentionally left dangling.
    logic unused_ab;
    assign unused_ab = ^{a_q, b_q};
endmodule

// File: doc/pipelined_subtractor.md
# pipelined_subtractor

Pipelined borrow-lookahead subtractor computing `a_i - b_i - borrow_i` over `WIDTH` bits, split into `STAGES` equal chunks. Each chunk resolves its borrow chain in one cycle and registers the partial result. It is the subtraction counterpart of the carry-lookahead adder path in the arithmetic unit, used where a full-width borrow chain cannot close timing. Valid/ready handshakes on both sides; the whole pipeline stalls under backpressure.

## Interface
- `WIDTH`, 16: operand and result width. Must be divisible by `STAGES`.
- `STAGES`, 4: number of pipeline stages, 1..`WIDTH`. Chunk width `CW = WIDTH/STAGES`.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `a_i` in `WIDTH`: minuend, unsigned or two's complement.
- `b_i` in `WIDTH`: subtrahend.
- `borrow_i` in 1: borrow-in, weight 1 at bit 0.
- `valid_i` in 1: input transaction valid.
- `ready_o` out 1: pipeline can accept an input this cycle.
- `diff_o` out `WIDTH`: `(a - b - borrow_in) mod 2^WIDTH`.
- `borrow_o` out 1: final borrow-out. 1 iff `a < b + borrow_in` (unsigned).
- `overflow_o` out 1: signed overflow of the subtraction.
- `valid_o` out 1: output transaction valid.
- `ready_i` in 1: downstream accepts the output.

## Operation
- Per bit j, with chunk borrow-in `br`:
  - generate `G[j] = ~a[j] & b[j]`
  - propagate `P[j] = ~(a[j] ^ b[j])`
  - `br[j+1] = G[j] | (P[j] & br[j])`
  - `diff[j] = a[j] ^ b[j] ^ br[j]`
- Stage k (0-based) processes bits `[k*CW +: CW]`:
  - Stage 0 takes `borrow_i`; stage k>0 takes the borrow registered by stage k-1.
  - Stage k registers: completed diff bits `[0 .. (k+1)*CW-1]`, the unprocessed operand bits above them, the chunk borrow-out, a valid bit, and `a[WIDTH-1]`/`b[WIDTH-1]` (for overflow).
- Final stage register drives the outputs:
  - `diff_o`
  - `borrow_o` = last chunk borrow-out
  - `overflow_o = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`
- Global advance enable: `adv = ~valid_o | ready_i`.
  - `ready_o = adv`, combinational from `valid_o` and `ready_i`.
- When `adv` = 1, every stage loads from its predecessor. Stage 0 loads the input with `valid = valid_i`.
- When `adv` = 0, all stage registers, valid bits and outputs hold.
- Bubbles (valid = 0) propagate like data. No bubble collapsing.
- The data path of an invalid stage is don't-care. Outputs are meaningful only while `valid_o` = 1.
- `STAGES = 1`: a single registered full-width borrow chain. Same handshake.

## Timing
- Reset (asynchronous, immediate): all valid bits 0, `valid_o` = 0, `diff_o` = 0, `borrow_o` = 0, `overflow_o` = 0, `ready_o` = 1.
- Handshake: an input is accepted at a rising edge with `valid_i & ready_o`. An output is consumed at a rising edge with `valid_o & ready_i`.
- Latency without stalls: a result accepted at edge n appears with `valid_o` = 1 after edge n+`STAGES-1`, i.e. on the cycle following the `STAGES`-th edge counting the accepting edge as the first.
- Throughput: one result per cycle while `ready_i` = 1.
- Output stability: while `valid_o` = 1 and `ready_i` = 0, `diff_o`, `borrow_o` and `overflow_o` hold stable.
- Simultaneous consume and accept on one edge: both take effect; the pipeline shifts by one.
- Ordering: no transaction is dropped or duplicated under any `ready_i` pattern. Results leave in input order.
- Reset mid-operation: all in-flight transactions are discarded. The first input accepted after `rst_i` deasserts behaves as in an empty pipeline.

## Test plan
Defaults `WIDTH=16`, `STAGES=4`.
- Borrow across all chunks: `0x0000 - 0x0001`, `borrow_i`=0 → `diff_o`=0xFFFF, `borrow_o`=1, `overflow_o`=0, `valid_o` 4 cycles after accept.
- Signed overflow: `0x8000 - 0x0001` → 0x7FFF, borrow 0, overflow 1. Then `0x7FFF - 0xFFFF` → 0x8000, borrow 1, overflow 1.
- Borrow-in: `0x1234 - 0x1234`, `borrow_i`=1 → 0xFFFF, borrow 1, overflow 0. With `borrow_i`=0 → 0x0000, borrow 0.
- Streaming: 1000 random back-to-back inputs with `ready_i`=1 → one output per cycle, each matching `(a-b-bin) mod 2^16` with correct borrow and overflow, in order.
- Backpressure: random `valid_i`/`ready_i` toggling over 1000 transactions → no loss or duplication, outputs stable while stalled, and `ready_o` = `~valid_o | ready_i` every cycle.
- Reset mid-flight: assert `rst_i` asynchronously with 3 transactions in flight → `valid_o` drops to 0 immediately. After release, a single input `0x0005 - 0x0003` emerges alone as 0x0002.
- Parameter sweep: repeat the streaming test for `STAGES` = 1, 2, 16 and `WIDTH` = 32 with `STAGES` = 8.
